dma_controller: RTL

Memory-to-memory copy engine on the CPU data bus, programmed through four memory-mapped registers. Its main use is moving tile attribute, tile data and palette tables from RAM into video memory. It is a second bus master: the top level muxes data_addr, data_wdata and data_wenable from the DMA when m_grant=1. The block also arbitrates that shared bus against the CPU, stalling the CPU while it owns the bus and yielding periodically for fairness.

---
 rtl/dma_controller.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/dma_controller.sv
// Memory-to-memory copy engine and data-bus arbiter.
// Copies LEN words from SRC to DST as RD/WR bus-cycle pairs, stalling the CPU while it
// owns the bus and yielding one cycle after every BURST words if the CPU is waiting.
module dma_controller #(
  parameter int unsigned BURST = 8,
  parameter int unsigned LEN_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_sel,
  input  logic [1:0]  cfg_reg,
  input  logic [31:0] cfg_wdata,
  input  logic        cfg_wenable,
  output logic [31:0] cfg_rdata,
  input  logic        cpu_req,
  output logic        cpu_stall,
  output logic        m_grant,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wenable,
  input  logic [31:0] m_rdata,
  input  logic        vblank,
  output logic        irq
);

  localparam int unsigned BCW = $clog2(BURST + 1);

  typedef enum logic [2:0] {StIdle, StWaitVb, StRd, StWr, StYield} state_e;

  state_e           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [BCW-1:0]   burst_q, burst_d;
  logic             wait_vb_q, wait_vb_d;
  logic             irq_en_q, irq_en_d;
  logic             done_q, done_d;

  logic             busy;
  logic             reg_we;
  logic             ctrl_we;
  logic             start_req;
  logic             done_clr;
  logic             xfer_last;
  logic             burst_full;
  logic [BCW-1:0]   burst_inc;

  assign busy       = (state_q != StIdle);
  assign reg_we     = cfg_sel & cfg_wenable;
  assign ctrl_we    = reg_we & (cfg_reg == 2'd3);
  // START is only honoured from IDLE; a START while busy is dropped.
  assign start_req  = ctrl_we & cfg_wdata[0] & ~busy;
  assign done_clr   = ctrl_we & cfg_wdata[9];
  assign burst_inc  = burst_q + BCW'(1);
  assign burst_full = (burst_inc == BCW'(BURST));
  assign xfer_last  = (len_q == LEN_W'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // WAIT_VB is taken from the same CTRL write that carries START.
        if (start_req && (len_q != '0)) begin
          state_d = cfg_wdata[1] ? StWaitVb : StRd;
        end
      end
      StWaitVb: begin
        if (vblank) begin
          state_d = StRd;
        end
      end
      StRd: begin
        state_d = StWr;
      end
      StWr: begin
        if (xfer_last) begin
          state_d = StIdle;
        end else if (burst_full && cpu_req) begin
          state_d = StYield;
        end else begin
          state_d = StRd;
        end
      end
      StYield: begin
        state_d = StRd;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Bus master outputs; grant only in RD/WR so the CPU access in a transition cycle completes.
  always_comb begin
    m_grant   = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_wenable = 4'h0;
    unique case (state_q)
      StRd: begin
        m_grant = 1'b1;
        m_addr  = src_q;
      end
      StWr: begin
        m_grant   = 1'b1;
        m_addr    = dst_q;
        m_wdata   = m_rdata;
        m_wenable = 4'hF;
      end
      default: begin
      end
    endcase
  end

  assign cpu_stall = m_grant & cpu_req;
  assign irq       = done_q & irq_en_q;

  // Register file and transfer datapath next-state.
  always_comb begin
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    burst_d   = burst_q;
    wait_vb_d = wait_vb_q;
    irq_en_d  = irq_en_q;
    done_d    = done_q;

    if (reg_we && !busy) begin
      unique case (cfg_reg)
        2'd0:    src_d = {cfg_wdata[31:2], 2'b00};
        2'd1:    dst_d = {cfg_wdata[31:2], 2'b00};
        2'd2:    len_d = cfg_wdata[LEN_W-1:0];
        default: begin
        end
      endcase
    end

    if (ctrl_we) begin
      wait_vb_d = cfg_wdata[1];
      irq_en_d  = cfg_wdata[2];
    end

    if (done_clr) begin
      done_d = 1'b0;
    end

    if (start_req) begin
      burst_d = '0;
      // A zero-length transfer completes immediately without touching the bus.
      if (len_q == '0) begin
        done_d = 1'b1;
      end
    end

    if (state_q == StWr) begin
      src_d   = src_q + 32'd4;
      dst_d   = dst_q + 32'd4;
      len_d   = len_q - LEN_W'(1);
      burst_d = burst_full ? '0 : burst_inc;
      // Completion sets DONE after the clear above, so a coincident clear loses.
      if (xfer_last) begin
        done_d  = 1'b1;
        burst_d = '0;
      end
    end
  end

  // Register file flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      wait_vb_q <= 1'b0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      burst_q   <= burst_d;
      wait_vb_q <= wait_vb_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
    end
  end

  // Register read mux; SRC/DST/LEN show live transfer progress.
  always_comb begin
    cfg_rdata = '0;
    unique case (cfg_reg)
      2'd0: cfg_rdata = src_q;
      2'd1: cfg_rdata = dst_q;
      2'd2: cfg_rdata[LEN_W-1:0] = len_q;
      2'd3: begin
        cfg_rdata[1] = wait_vb_q;
        cfg_rdata[2] = irq_en_q;
        cfg_rdata[8] = busy;
        cfg_rdata[9] = done_q;
      end
      default: begin
      end
    endcase
  end

endmodule
